// File: rtl/phase_scheduler.sv
// Next-phase/duration scheduler for the intersection light sequencer.
// Answers each sched_req one cycle later and tracks pedestrian and side-road requests.
module phase_scheduler #(
  parameter int TBASE = 6,
  parameter int TEXT  = 3,
  parameter int TYEL  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       walk_btn,
  input  logic       sensor,
  input  logic       preempt,
  input  logic       sched_req,
  output logic       sched_ack,
  output logic [2:0] phase,
  output logic [3:0] duration,
  output logic       walk_light,
  output logic       walk_pending,
  output logic       sensor_pending
);

  typedef enum logic [2:0] {
    PH_GR = 3'd0,
    PH_YR = 3'd1,
    PH_RG = 3'd2,
    PH_RY = 3'd3,
    PH_RR = 3'd4
  } phase_e;

  localparam logic [3:0] T_BASE     = 4'(TBASE);
  localparam logic [3:0] T_EXT      = 4'(TEXT);
  localparam logic [3:0] T_YEL      = 4'(TYEL);
  localparam logic [3:0] T_BASE_EXT = 4'(TBASE + TEXT);
  localparam logic [3:0] T_LONG     = T_BASE + T_BASE;

  phase_e     phase_q, phase_d;
  logic [3:0] dur_q, dur_d;
  logic       ack_q, ack_d;
  logic       walk_light_q, walk_light_d;
  logic       walk_pend_q, walk_pend_d;
  logic       sens_pend_q, sens_pend_d;
  logic       decide_s;
  logic       use_walk_s;
  logic       use_sens_s;

  // Next-phase decision and request latching.
  always_comb begin
    phase_d    = phase_q;
    dur_d      = dur_q;
    use_walk_s = 1'b0;
    use_sens_s = 1'b0;
    decide_s   = sched_req & ~ack_q;
    ack_d      = decide_s;

    if (decide_s && preempt) begin
      // Emergency: drive toward main-green and hold there; requests stay latched.
      case (phase_q)
        PH_GR:   begin phase_d = PH_GR; dur_d = T_BASE; end
        PH_YR:   begin phase_d = PH_RR; dur_d = T_YEL;  end
        PH_RG:   begin phase_d = PH_RY; dur_d = T_YEL;  end
        PH_RY:   begin phase_d = PH_GR; dur_d = T_BASE; end
        PH_RR:   begin phase_d = PH_GR; dur_d = T_BASE; end
        default: begin phase_d = PH_RY; dur_d = T_YEL;  end
      endcase
    end else if (decide_s) begin
      case (phase_q)
        PH_GR: begin
          phase_d = PH_YR;
          dur_d   = T_YEL;
        end
        PH_YR: begin
          if (walk_pend_q) begin
            phase_d    = PH_RR;
            dur_d      = T_EXT;
            use_walk_s = 1'b1;
          end else begin
            phase_d    = PH_RG;
            dur_d      = sens_pend_q ? T_BASE_EXT : T_BASE;
            use_sens_s = 1'b1;
          end
        end
        PH_RR: begin
          phase_d    = PH_RG;
          dur_d      = sens_pend_q ? T_BASE_EXT : T_BASE;
          use_sens_s = 1'b1;
        end
        PH_RG: begin
          phase_d = PH_RY;
          dur_d   = T_YEL;
        end
        PH_RY: begin
          phase_d = PH_GR;
          dur_d   = (walk_pend_q | sens_pend_q) ? T_BASE : T_LONG;
        end
        default: begin
          phase_d = PH_RY;
          dur_d   = T_YEL;
        end
      endcase
    end else begin
      phase_d = phase_q;
      dur_d   = dur_q;
    end

    // A consuming decision beats a same-cycle set.
    if (use_walk_s) begin
      walk_pend_d = 1'b0;
    end else if (walk_btn && (phase_q != PH_RR)) begin
      walk_pend_d = 1'b1;
    end else begin
      walk_pend_d = walk_pend_q;
    end

    if (use_sens_s) begin
      sens_pend_d = 1'b0;
    end else if (sensor && (phase_q != PH_RG)) begin
      sens_pend_d = 1'b1;
    end else begin
      sens_pend_d = sens_pend_q;
    end

    walk_light_d = (phase_d == PH_RR);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= PH_RY;
      dur_q        <= T_YEL;
      ack_q        <= 1'b0;
      walk_light_q <= 1'b0;
      walk_pend_q  <= 1'b0;
      sens_pend_q  <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      dur_q        <= dur_d;
      ack_q        <= ack_d;
      walk_light_q <= walk_light_d;
      walk_pend_q  <= walk_pend_d;
      sens_pend_q  <= sens_pend_d;
    end
  end

  assign sched_ack      = ack_q;
  assign phase          = phase_q;
  assign duration       = dur_q;
  assign walk_light     = walk_light_q;
  assign walk_pending   = walk_pend_q;
  assign sensor_pending = sens_pend_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench for phase_scheduler: a cycle model pushes expected decisions,
// and each sched_ack pops and compares one.
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       walk_btn, sensor, preempt, sched_req;
  logic       sched_ack;
  logic [2:0] phase;
  logic [3:0] duration;
  logic       walk_light, walk_pending, sensor_pending;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  // Expected decision: {walk_light, phase[2:0], duration[3:0]}
  logic [7:0] sb_q[$];

  int   m_phase, m_dur;
  logic m_ack, m_wp, m_sp;

  localparam int B = 6;
  localparam int X = 3;
  localparam int Y = 2;

  phase_scheduler #(.TBASE(B), .TEXT(X), .TYEL(Y)) dut (
    .clk(clk), .reset(reset), .walk_btn(walk_btn), .sensor(sensor),
    .preempt(preempt), .sched_req(sched_req), .sched_ack(sched_ack),
    .phase(phase), .duration(duration), .walk_light(walk_light),
    .walk_pending(walk_pending), .sensor_pending(sensor_pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 3; m_dur = Y; m_ack = 1'b0; m_wp = 1'b0; m_sp = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle of inputs, advance the model, then check the DUT after the edge.
  task automatic cycle(input logic wb, input logic sn, input logic pe, input logic rq);
    logic dec, cw, cs, nwp, nsp;
    int np, nd;
    logic [7:0] e;
    walk_btn = wb; sensor = sn; preempt = pe; sched_req = rq;
    dec = rq && !m_ack;
    np = m_phase; nd = m_dur; cw = 1'b0; cs = 1'b0;
    if (dec && pe) begin
      if (m_phase == 1)      begin np = 4; nd = Y; end
      else if (m_phase == 2) begin np = 3; nd = Y; end
      else                   begin np = 0; nd = B; end
    end else if (dec) begin
      if (m_phase == 0)      begin np = 1; nd = Y; end
      else if (m_phase == 2) begin np = 3; nd = Y; end
      else if (m_phase == 3) begin np = 0; nd = (m_wp || m_sp) ? B : 2 * B; end
      else if (m_phase == 1 && m_wp) begin np = 4; nd = X; cw = 1'b1; end
      else begin np = 2; nd = m_sp ? B + X : B; cs = 1'b1; end
    end
    nwp = cw ? 1'b0 : ((wb && m_phase != 4) ? 1'b1 : m_wp);
    nsp = cs ? 1'b0 : ((sn && m_phase != 2) ? 1'b1 : m_sp);
    if (dec) sb_q.push_back({(np == 4), 3'(np), 4'(nd)});
    @(posedge clk); #1;
    m_phase = np; m_dur = nd; m_ack = dec; m_wp = nwp; m_sp = nsp;
    check_eq("ack", 32'(sched_ack), 32'(m_ack));
    check_eq("walk_pend", 32'(walk_pending), 32'(m_wp));
    check_eq("sens_pend", 32'(sensor_pending), 32'(m_sp));
    check_eq("walk_light", 32'(walk_light), 32'(m_phase == 4));
    if (sched_ack) begin
      if (sb_q.size() == 0) begin
        check_eq("orphan_ack", 32'(sched_ack), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("phase", 32'(phase), 32'(e[6:4]));
        check_eq("duration", 32'(duration), 32'(e[3:0]));
        check_eq("dec_walk_light", 32'(walk_light), 32'(e[7]));
      end
    end
  endtask

  // One request followed by two idle cycles with preempt held.
  task automatic req(input logic wb, input logic sn, input logic pe);
    cycle(wb, sn, pe, 1'b1);
    cycle(1'b0, 1'b0, pe, 1'b0);
    cycle(1'b0, 1'b0, pe, 1'b0);
  endtask

  task automatic idle(input logic wb, input logic sn);
    cycle(wb, sn, 1'b0, 1'b0);
  endtask

  initial begin
    int base_ph[4] = '{0, 1, 2, 3};
    int base_du[4] = '{12, 2, 6, 2};
    reset = 1'b1; walk_btn = 1'b0; sensor = 1'b0; preempt = 1'b0; sched_req = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_phase", 32'(phase), 32'd3);
    check_eq("rst_dur", 32'(duration), 32'd2);
    check_eq("rst_ack", 32'(sched_ack), 32'd0);
    check_eq("rst_wl", 32'(walk_light), 32'd0);
    check_eq("rst_wp", 32'(walk_pending), 32'd0);
    check_eq("rst_sp", 32'(sensor_pending), 32'd0);
    reset = 1'b0;
    idle(1'b0, 1'b0);

    // Base cycle against fixed values
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("base_phase", 32'(phase), 32'(base_ph[i]));
      check_eq("base_dur", 32'(duration), 32'(base_du[i]));
      idle(1'b0, 1'b0); idle(1'b0, 1'b0);
    end

    // Walk service, pressed during R_y
    idle(1'b1, 1'b0);
    req(1'b0, 1'b0, 1'b0);   // (0,6)
    req(1'b0, 1'b0, 1'b0);   // (1,2)
    req(1'b0, 1'b0, 1'b0);   // (4,3)
    req(1'b0, 1'b0, 1'b0);   // (2,6)
    req(1'b0, 1'b0, 1'b0);   // (3,2)

    // Sensor extension
    req(1'b0, 1'b0, 1'b0);   // (0,12)
    idle(1'b0, 1'b1);
    req(1'b0, 1'b0, 1'b0);   // (1,2)
    req(1'b0, 1'b0, 1'b0);   // (2,9)
    idle(1'b0, 1'b1); idle(1'b0, 1'b1);
    req(1'b0, 1'b0, 1'b0);   // (3,2)

    // Preemption
    req(1'b0, 1'b0, 1'b0);   // (0,12)
    req(1'b0, 1'b0, 1'b0);   // (1,2)
    req(1'b0, 1'b0, 1'b0);   // (2,6)
    req(1'b0, 1'b0, 1'b1);   // (3,2)
    req(1'b0, 1'b0, 1'b1);   // (0,6)
    idle(1'b1, 1'b0);
    req(1'b0, 1'b0, 1'b1);   // (0,6) hold
    req(1'b0, 1'b0, 1'b0);   // (1,2)
    req(1'b0, 1'b0, 1'b1);   // (4,2), walk kept
    req(1'b0, 1'b0, 1'b1);   // (0,6)
    req(1'b0, 1'b0, 1'b0);   // (1,2)
    req(1'b0, 1'b0, 1'b0);   // (4,3) walk served
    req(1'b0, 1'b0, 1'b0);   // (2,6)

    // Held request: one decision only
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0); idle(1'b0, 1'b0);
    // Back-to-back N and N+2
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0); idle(1'b0, 1'b0);

    // Walk press coinciding with the consuming Y_r decision
    idle(1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0); idle(1'b0, 1'b0);
    req(1'b0, 1'b0, 1'b0);

    // Reset while sched_ack is high
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("pre_rst_ack", 32'(sched_ack), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_ack", 32'(sched_ack), 32'd0);
    check_eq("mid_rst_phase", 32'(phase), 32'd3);
    check_eq("mid_rst_dur", 32'(duration), 32'd2);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("post_rst_phase", 32'(phase), 32'd0);
    idle(1'b0, 1'b0); idle(1'b0, 1'b0);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
